// File: rtl/pheap_root_pkg.sv
// Shared types for the pipelined max-heap: opcodes, heap entries, root FSM
// states and the token passed between levels.
package pheapTypes;
  localparam int PH_LEVELS = 2;
  localparam int PH_WIDTH  = 32;

  typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ENQ_GAP = 2'd1, DEQ_WAIT = 2'd2} root_state_t;

  typedef struct packed {
    logic                 active;
    logic [PH_LEVELS:0]   capacity;
    logic [PH_WIDTH-1:0]  priorityValue;
  } entry_t;

  typedef struct packed {
    opcode_t              op;
    logic [PH_WIDTH-1:0]  value;
    logic                 pos;
  } token_t;
endpackage

// File: rtl/pheap_root_if.sv
// Request/response bus of the heap root plus its token/promotion link to level 1.
interface pheap_root_if import pheapTypes::*; #(parameter int WIDTH = 32);
  logic             req_valid;
  opcode_t          req_op;
  logic [WIDTH-1:0] req_value;
  logic             req_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_value;
  logic             resp_err;
  logic             tok_valid;
  opcode_t          tok_op;
  logic [WIDTH-1:0] tok_value;
  logic             tok_pos;
  logic             up_valid;
  logic [WIDTH-1:0] up_value;
  logic             up_pos;

  // user / level-1 side
  modport master (
    output req_valid, req_op, req_value, up_valid, up_value, up_pos,
    input  req_ready, resp_valid, resp_value, resp_err, tok_valid, tok_op, tok_value, tok_pos
  );

  // root stage side
  modport slave (
    input  req_valid, req_op, req_value, up_valid, up_value, up_pos,
    output req_ready, resp_valid, resp_value, resp_err, tok_valid, tok_op, tok_value, tok_pos
  );
endinterface

// File: rtl/pheap_root.sv
// Root (level-0) stage of the pipelined max-heap. Holds the maximum, tracks
// free space in the two level-1 subtrees and issues tokens downward.
module pheap_root import pheapTypes::*; #(
  parameter int LEVELS = 2,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  pheap_root_if.slave       bus,
  output logic [LEVELS+1:0] count,
  output logic              empty,
  output logic              full
);
  localparam int CW = LEVELS + 2;
  localparam logic [CW-1:0]     CAP  = {1'b0, {(LEVELS+1){1'b1}}};
  localparam logic [LEVELS-1:0] CCAP = {LEVELS{1'b1}};

  root_state_t      state_q, state_d;
  logic             root_act_q, root_act_d;
  logic             root_pend_q, root_pend_d;
  logic [WIDTH-1:0] root_val_q, root_val_d;
  logic [LEVELS-1:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d;
  logic [CW-1:0]    count_q, count_d;
  logic             resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [WIDTH-1:0] resp_value_q, resp_value_d;
  logic             tok_valid_q, tok_valid_d, tok_pos_q, tok_pos_d;
  opcode_t          tok_op_q, tok_op_d;
  logic [WIDTH-1:0] tok_value_q, tok_value_d;
  logic             is_full, is_empty;

  assign is_full  = (count_q == CAP);
  assign is_empty = (count_q == '0);

  // Next-state: request handling in IDLE, bubble after enqueue, wait for promotion after dequeue
  always_comb begin
    state_d      = state_q;
    root_act_d   = root_act_q;
    root_pend_d  = root_pend_q;
    root_val_d   = root_val_q;
    cap_l_d      = cap_l_q;
    cap_r_d      = cap_r_q;
    count_d      = count_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_value_d = resp_value_q;
    tok_valid_d  = 1'b0;
    tok_op_d     = tok_op_q;
    tok_value_d  = tok_value_q;
    tok_pos_d    = tok_pos_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (bus.req_op == LEQ) begin
          if (is_full) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!root_act_q) begin
            root_act_d = 1'b1;
            root_val_d = bus.req_value;
            count_d    = count_q + 1'b1;
          end else begin
            // larger value stays at the root, smaller one travels down
            if (bus.req_value > root_val_q) begin
              root_val_d  = bus.req_value;
              tok_value_d = root_val_q;
            end else begin
              tok_value_d = bus.req_value;
            end
            if (cap_l_q != '0) begin
              tok_pos_d = 1'b0;
              cap_l_d   = cap_l_q - 1'b1;
            end else begin
              tok_pos_d = 1'b1;
              cap_r_d   = cap_r_q - 1'b1;
            end
            tok_valid_d = 1'b1;
            tok_op_d    = LEQ;
            count_d     = count_q + 1'b1;
            state_d     = ENQ_GAP;
          end
        end else begin
          if (is_empty) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            resp_valid_d = 1'b1;
            resp_value_d = root_val_q;
            count_d      = count_q - 1'b1;
            if (count_q == CW'(1)) begin
              root_act_d = 1'b0;
            end else begin
              tok_valid_d = 1'b1;
              tok_op_d    = DEQ;
              tok_pos_d   = 1'b0;
              root_pend_d = 1'b1;
              state_d     = DEQ_WAIT;
            end
          end
        end
      end
      ENQ_GAP: state_d = IDLE;
      DEQ_WAIT: if (bus.up_valid) begin
        root_val_d  = bus.up_value;
        root_pend_d = 1'b0;
        if (bus.up_pos) cap_r_d = (cap_r_q == CCAP) ? cap_r_q : cap_r_q + 1'b1;
        else            cap_l_d = (cap_l_q == CCAP) ? cap_l_q : cap_l_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      root_act_q   <= 1'b0;
      root_pend_q  <= 1'b0;
      root_val_q   <= '0;
      cap_l_q      <= CCAP;
      cap_r_q      <= CCAP;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_value_q <= '0;
      tok_valid_q  <= 1'b0;
      tok_op_q     <= LEQ;
      tok_value_q  <= '0;
      tok_pos_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      root_act_q   <= root_act_d;
      root_pend_q  <= root_pend_d;
      root_val_q   <= root_val_d;
      cap_l_q      <= cap_l_d;
      cap_r_q      <= cap_r_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_value_q <= resp_value_d;
      tok_valid_q  <= tok_valid_d;
      tok_op_q     <= tok_op_d;
      tok_value_q  <= tok_value_d;
      tok_pos_q    <= tok_pos_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_value = resp_value_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.tok_valid  = tok_valid_q;
  assign bus.tok_op     = tok_op_q;
  assign bus.tok_value  = tok_value_q;
  assign bus.tok_pos    = tok_pos_q;
  assign count          = count_q;
  assign empty          = is_empty;
  assign full           = is_full;
endmodule

// File: doc/pheap_root.md
Name: pheap_root

Overview:
- Level-0 (root) stage of the pipelined max-heap, directly upstream of the per-level `leq` stages.
- Accepts enqueue/dequeue requests from the user interface and holds the root entry in a register.
- Tracks free capacity of the two level-1 subtrees and issues operation tokens (op, value, position) to level 1.
- On dequeue, returns the maximum and refills the root from the value level 1 promotes upward.

Parameters:
- LEVELS, 2, number of heap levels below the root; each level-1 subtree holds 2^LEVELS-1 entries; total capacity CAP = 2^(LEVELS+1)-1.
- WIDTH, 32, priority value width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_op  in  opcode_t  LEQ = enqueue, DEQ = dequeue
- req_value  in  WIDTH  priority to enqueue (ignored for DEQ)
- req_ready  out  1  request accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle pulse, result of a DEQ or an error
- resp_value  out  WIDTH  dequeued maximum
- resp_err  out  1  qualifies resp_valid: DEQ on empty or LEQ on full
- tok_valid  out  1  token to level 1 valid (single-cycle pulse)
- tok_op  out  opcode_t  token operation
- tok_value  out  WIDTH  value carried down (LEQ)
- tok_pos  out  1  level-1 slot: 0 = left, 1 = right
- up_valid  in  1  level 1 returns the promoted child after a DEQ token
- up_value  in  WIDTH  promoted value
- up_pos  in  1  slot the promoted value came from
- count  out  LEVELS+2  occupancy
- empty  out  1  count == 0
- full  out  1  count == CAP

Behaviour:
- Reset:
  - root.active = 0; cap_l = cap_r = 2^LEVELS-1; count = 0; state = IDLE.
  - req_ready = 1; resp_valid, resp_err, tok_valid = 0; resp_value, tok_value = 0.
- FSM states: IDLE, ENQ_GAP, DEQ_WAIT. req_ready = (state == IDLE).
- LEQ accepted in IDLE:
  - If full: resp_valid = resp_err = 1 next cycle; no state change.
  - If root inactive: root = {active = 1, value = req_value}; count+1; no token; stay IDLE.
  - Otherwise, with v = req_value:
    - If v > root.value (strictly greater), root.value = v and the carried value is the old root; else the carried value is v.
    - tok_pos = 0 if cap_l != 0, else 1; decrement the chosen capacity.
    - Next cycle: tok_valid = 1, tok_op = LEQ, tok_value = carried value; count+1.
    - Go to ENQ_GAP; return to IDLE the following cycle. The one-cycle bubble enforces pipeline spacing.
- DEQ accepted in IDLE:
  - If empty: resp_valid = resp_err = 1 next cycle.
  - Otherwise, next cycle: resp_valid = 1, resp_value = root.value, count-1.
    - If count == 1: root.active = 0; stay IDLE.
    - Else: tok_valid = 1, tok_op = DEQ, tok_pos = 0; root marked pending; go to DEQ_WAIT.
- DEQ_WAIT:
  - Holds until up_valid, which may arrive any number of cycles later.
  - On up_valid: root.value = up_value; the cap for up_pos increments (saturating at 2^LEVELS-1); go to IDLE.
  - req_ready = 0 throughout DEQ_WAIT.
- Boundary rules:
  - up_valid outside DEQ_WAIT is ignored.
  - Ties do not swap.
  - count never wraps: guarded by full/empty.
  - Reset mid-operation (any state) returns everything to reset values the next edge; an outstanding token is abandoned. Downstream levels share rst.
- All outputs are registered. Latency from request handshake to resp/tok is 1 cycle.

Decomposition:
- In package pheapTypes: entry_t (active, capacity, priorityValue), opcode_t (LEQ, DEQ), plus a new root_state_t enum and a token_t struct {op, value, pos}.
- Derive CAP locally from LEVELS.
- No sub-module; capacity counters and the FSM stay in one module.

Test Plan (LEVELS = 2, CAP = 7, child cap = 3):
- Reset -> empty=1, full=0, count=0, req_ready=1, tok_valid=0, resp_valid=0.
- LEQ 5 on empty heap -> root=5, count=1, no tok_valid. Then LEQ 9 -> next cycle tok_valid, tok_op=LEQ, tok_value=5, tok_pos=0, root=9; req_ready low for exactly one cycle.
- Seven LEQs -> full=1, count=7; the left subtree fills before tok_pos=1 appears. An eighth LEQ -> resp_valid=1, resp_err=1, count stays 7.
- With root=9 and count=2, DEQ -> next cycle resp_value=9, resp_err=0, tok DEQ pos 0, req_ready=0. Then up_valid, up_value=5, up_pos=0 -> root=5, req_ready=1, count=1.
- DEQ on empty -> resp_valid=1, resp_err=1, no token. LEQ 3 then DEQ -> resp_value=3, empty=1, no token.
- Assert rst while in DEQ_WAIT -> next cycle state IDLE, count=0, req_ready=1. A late up_valid is ignored.
